ct_ifu_pcd_bound_sel: RTL and testbench
=======================================

Name: ct_ifu_pcd_bound_sel

Overview:
- Consumes one 128-bit fetch line plus its 32-bit precode vector.
- Resolves the real instruction-boundary chain for the line, using either the "h1 is a start" chain or the "h1 is a continuation" chain.
- Masks halfwords that come before the fetch entry point and tracks 32-bit instructions that straddle two lines.
- Sits between the precode stage and the IFU instruction buffer, with one registered valid/ready pipeline stage.

Parameters:
- LINE_HW, 8, halfwords per fetch line; the RTL is fixed at 8 and the value is checked by an elaboration assertion.
- CNT_W, 32, perf-counter width; used only when the optional feature is compiled in.

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset; single clock, reset asynchronous and active-high
- pcd_flush  in  1  synchronous flush of the stage and of carry state
- pcd_in_vld  in  1  input line valid
- pcd_in_rdy  out  1  stage can accept
- pcd_in_redirect  in  1  line is the first line after a redirect; ignore carry-in
- pcd_in_start_hw  in  3  entry halfword index, 0=h1 .. 7=h8
- pcd_in_data  in  128  inst data; h1=[127:112] .. h8=[15:0]
- pcd_in_pre_code  in  32  per halfword hn, bits [31-4(n-1) -: 4] = {ab_br, br, bry1, bry0}
- pcd_out_vld  out  1  output valid
- pcd_out_rdy  in  1  downstream accept
- pcd_out_data  out  128  registered copy of input data
- pcd_out_bnd  out  8  instruction-start mask; bit7=h1 .. bit0=h8
- pcd_out_br  out  8  conditional or unconditional direct-branch start mask
- pcd_out_ab_br  out  8  jal / c.j start mask
- pcd_out_first_br_vld  out  1  any bit of pcd_out_br is set
- pcd_out_first_br_idx  out  3  program-order index of the first br; 0=h1
- pcd_out_cross_vld  out  1  h1 of this line completes a 32-bit instruction started in the previous line
- pcd_out_cross_hw  out  16  low halfword of that straddling instruction (previous line's h8)

Behaviour:
- Reset:
  - all *_vld outputs are 0;
  - masks and idx are 0;
  - data and cross_hw are 0;
  - carry_q=0 and carry_hw_q=0.
- Handshake:
  - pcd_in_rdy = !pcd_out_vld || pcd_out_rdy.
  - Accept = pcd_in_vld && pcd_in_rdy.
  - Latency is 1 cycle; all outputs are registered.
  - Output is held stable while pcd_out_vld && !pcd_out_rdy.
- Carry-in: cin = carry_q && !pcd_in_redirect.
- Chain select:
  - If cin=1, use the bry0 chain.
  - Otherwise use the bry1 chain if bry1 of h[start_hw] is set, else bry0.
  - When cin=1, start_hw is ignored and treated as 0.
- Masking: valid_hw[k] = (k >= start_hw).
  - bnd = chain & valid_hw.
  - br = bnd & br_bits; ab_br = bnd & ab_br_bits (ab_br is a subset of br).
- first_br_idx: lowest program-order index with a br bit set (priority h1 first).
- Carry-out:
  - cout = bnd[h8] && (h8 data[1:0]==2'b11).
  - On accept: carry_q<=cout and carry_hw_q<=h8 data.
  - pcd_out_cross_vld<=cin and pcd_out_cross_hw<=carry_hw_q.
- Flush has priority over accept in the same cycle:
  - pcd_out_vld<=0;
  - carry_q<=0;
  - the incoming line is dropped.
- Carry state changes only on accept. A stalled output never alters carry.
- Reset mid-stream clears carry, so the first line after reset is treated as non-cross.

Optional Feature:
- CT_IFU_PCD_PERF_CNT_EN defined:
  - adds outputs pcd_perf_line_cnt[CNT_W-1:0] (accepted lines) and pcd_perf_cross_cnt[CNT_W-1:0] (accepted lines with cin=1);
  - both counters saturate at all-ones;
  - both reset to 0 and are not cleared by flush.
- Undefined: those ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ct_ifu_pcd_pkg:
  - LINE_HW;
  - typedef pcd_hw_t (4-bit {ab_br, br, bry1, bry0}) with field-position constants;
  - function hw_idx_to_bit(k) = 7-k.
- One sub-module, ct_ifu_pcd_first_br, an 8-bit program-order priority encoder producing vld and idx.

Test Plan:
- Eight c.nop halfwords 0x0001, start_hw=0, no carry:
  - bnd=8'hFF, br=0, cross_vld=0, carry_q=0.
- Four 32-bit nops (h odd=0x0013, h even=0x0000), start_hw=0:
  - bnd=8'hAA, carry_q=0.
- Line with h1..h7=0x0001 and h8=0x0013, then next line h1=0x0000 and h2..h8=0x0001:
  - line 1: bnd=8'hFF, carry_q=1;
  - line 2: cross_vld=1, cross_hw=16'h0013, bnd=8'h7F.
- h3=0xA001 (c.j), h5=0xC001 (c.beqz), rest c.nop, start_hw=1:
  - bnd=8'h7F, br=8'h28, ab_br=8'h20, first_br_idx=2.
- Carry pending, then a redirect line with start_hw=4 of c.nops:
  - cross_vld=0, bnd=8'h0F.
- Output stalled (pcd_out_rdy=0) for 3 cycles, then flush asserted together with pcd_in_vld:
  - outputs are held during the stall;
  - after flush, pcd_out_vld=0 and carry_q=0;
  - no line is accepted.

Source files
------------

// File: rtl/ct_ifu_pcd_pkg.sv
// Shared types and helpers for the precode boundary-select stage.
// Contents: LINE_HW, CNT_W, per-halfword precode nibble type pcd_hw_t with field positions,
//           and hw_idx_to_bit() mapping a program-order halfword index (0=h1) to its mask bit.
package ct_ifu_pcd_pkg;

   localparam int LINE_HW = 8;
   localparam int CNT_W   = 32;

   // Per-halfword precode nibble {ab_br, br, bry1, bry0}.
   typedef struct packed {
      logic ab_br;
      logic br;
      logic bry1;
      logic bry0;
   } pcd_hw_t;

   localparam int AB_BR_POS = 3;
   localparam int BR_POS    = 2;
   localparam int BRY1_POS  = 1;
   localparam int BRY0_POS  = 0;

   // Masks and vectors are stored h1 in the MSB, so program index k lives at bit 7-k.
   function automatic logic [2:0] hw_idx_to_bit(input logic [2:0] k);
      return 3'd7 - k;
   endfunction

endpackage

// File: rtl/ct_ifu_pcd_bound_sel_if.sv
// Bus bundle between the precode stage, the boundary-select stage and the instruction buffer.
// Input side: pcd_flush, pcd_in_vld/rdy, redirect, start_hw, data, pre_code.
// Output side: pcd_out_vld/rdy, data, bnd/br/ab_br masks, first-br, cross; perf counters when
// CT_IFU_PCD_PERF_CNT_EN is defined.
interface ct_ifu_pcd_bound_sel_if;
   import ct_ifu_pcd_pkg::*;

   logic         pcd_flush;
   logic         pcd_in_vld;
   logic         pcd_in_rdy;
   logic         pcd_in_redirect;
   logic [2:0]   pcd_in_start_hw;
   logic [127:0] pcd_in_data;
   logic [31:0]  pcd_in_pre_code;
   logic         pcd_out_vld;
   logic         pcd_out_rdy;
   logic [127:0] pcd_out_data;
   logic [7:0]   pcd_out_bnd;
   logic [7:0]   pcd_out_br;
   logic [7:0]   pcd_out_ab_br;
   logic         pcd_out_first_br_vld;
   logic [2:0]   pcd_out_first_br_idx;
   logic         pcd_out_cross_vld;
   logic [15:0]  pcd_out_cross_hw;
`ifdef CT_IFU_PCD_PERF_CNT_EN
   logic [CNT_W-1:0] pcd_perf_line_cnt;
   logic [CNT_W-1:0] pcd_perf_cross_cnt;
`endif

   // Upstream / environment side.
   modport master (
      output pcd_flush, pcd_in_vld, pcd_in_redirect, pcd_in_start_hw, pcd_in_data,
             pcd_in_pre_code, pcd_out_rdy,
      input  pcd_in_rdy, pcd_out_vld, pcd_out_data, pcd_out_bnd, pcd_out_br, pcd_out_ab_br,
             pcd_out_first_br_vld, pcd_out_first_br_idx, pcd_out_cross_vld, pcd_out_cross_hw
`ifdef CT_IFU_PCD_PERF_CNT_EN
      , input pcd_perf_line_cnt, pcd_perf_cross_cnt
`endif
   );

   // Boundary-select stage side.
   modport slave (
      input  pcd_flush, pcd_in_vld, pcd_in_redirect, pcd_in_start_hw, pcd_in_data,
             pcd_in_pre_code, pcd_out_rdy,
      output pcd_in_rdy, pcd_out_vld, pcd_out_data, pcd_out_bnd, pcd_out_br, pcd_out_ab_br,
             pcd_out_first_br_vld, pcd_out_first_br_idx, pcd_out_cross_vld, pcd_out_cross_hw
`ifdef CT_IFU_PCD_PERF_CNT_EN
      , output pcd_perf_line_cnt, pcd_perf_cross_cnt
`endif
   );

endinterface

// File: rtl/ct_ifu_pcd_first_br.sv
// Purpose: program-order priority encoder, finds the first set bit with h1 (bit7) winning.
// Latency: combinational. Backpressure: none.
// Ports: br_i mask (bit7=h1), vld_o any bit set, idx_o program index of first set bit (0=h1).
module ct_ifu_pcd_first_br
   import ct_ifu_pcd_pkg::*;
(
   input  logic [7:0] br_i,
   output logic       vld_o,
   output logic [2:0] idx_o
);

   always_comb begin
      vld_o = |br_i;
      idx_o = '0;
      // Scan from h8 back to h1 so the earliest program-order hit is written last.
      for (int k = LINE_HW - 1; k >= 0; k--) begin
         if (br_i[hw_idx_to_bit(3'(k))]) begin
            idx_o = 3'(k);
         end
      end
   end

endmodule

// File: rtl/ct_ifu_pcd_bound_sel.sv
// Purpose: resolve instruction-start chain of a fetch line, mask pre-entry halfwords, track straddling 32-bit insts.
// Latency: 1 cycle, all outputs registered.
// Backpressure: pcd_in_rdy = !pcd_out_vld || pcd_out_rdy; output held while stalled.
// Ports: forever_cpuclk, cpurst (async, active-high), bus (ct_ifu_pcd_bound_sel_if.slave).
// Optional: CT_IFU_PCD_PERF_CNT_EN adds saturating accepted-line / cross-line counters.
module ct_ifu_pcd_bound_sel #(
   parameter int LINE_HW = 8,
   parameter int CNT_W   = 32
) (
   input  logic                         forever_cpuclk,
   input  logic                         cpurst,
   ct_ifu_pcd_bound_sel_if.slave        bus
);
   import ct_ifu_pcd_pkg::*;

   if (LINE_HW != ct_ifu_pcd_pkg::LINE_HW || CNT_W != ct_ifu_pcd_pkg::CNT_W) begin : g_param_chk
      $error("ct_ifu_pcd_bound_sel: LINE_HW must be 8 and CNT_W must match the package");
   end

   pcd_hw_t      pc [LINE_HW];
   logic [7:0]   chain0, chain1, chain, valid_hw;
   logic [7:0]   bnd_d, br_d, ab_br_d;
   logic         first_br_vld_d;
   logic [2:0]   first_br_idx_d;
   logic [2:0]   start_eff;
   logic         cin, sel1, cout, in_rdy, take;

   logic         out_vld_q;
   logic [127:0] out_data_q;
   logic [7:0]   bnd_q, br_q, ab_br_q;
   logic         first_br_vld_q;
   logic [2:0]   first_br_idx_q;
   logic         cross_vld_q;
   logic [15:0]  cross_hw_q;
   logic         carry_q;
   logic [15:0]  carry_hw_q;

   assign in_rdy = !out_vld_q || bus.pcd_out_rdy;
   // Flush wins over accept: the line presented alongside a flush is dropped.
   assign take   = bus.pcd_in_vld && in_rdy && !bus.pcd_flush;

   always_comb begin
      cin       = carry_q && !bus.pcd_in_redirect;
      // A pending straddle means h1 is the tail of the previous instruction, so the entry point
      // is forced to h1 and the "h1 is a continuation" chain (bry0) is the only legal one.
      start_eff = cin ? 3'd0 : bus.pcd_in_start_hw;
      for (int b = 0; b < LINE_HW; b++) begin
         pc[b]       = bus.pcd_in_pre_code[4*b +: 4];
         chain0[b]   = pc[b].bry0;
         chain1[b]   = pc[b].bry1;
         valid_hw[b] = (3'(LINE_HW - 1 - b) >= start_eff);
      end
      sel1  = !cin && chain1[hw_idx_to_bit(start_eff)];
      chain = sel1 ? chain1 : chain0;
      bnd_d = chain & valid_hw;
      br_d    = '0;
      ab_br_d = '0;
      for (int b = 0; b < LINE_HW; b++) begin
         br_d[b]    = bnd_d[b] && pc[b].br;
         ab_br_d[b] = bnd_d[b] && pc[b].ab_br;
      end
      // An instruction starting at h8 with a 32-bit opcode spills into the next line.
      cout = bnd_d[0] && (bus.pcd_in_data[1:0] == 2'b11);
   end

   ct_ifu_pcd_first_br u_first_br (
      .br_i  (br_d),
      .vld_o (first_br_vld_d),
      .idx_o (first_br_idx_d)
   );

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         out_vld_q      <= 1'b0;
         out_data_q     <= '0;
         bnd_q          <= '0;
         br_q           <= '0;
         ab_br_q        <= '0;
         first_br_vld_q <= 1'b0;
         first_br_idx_q <= '0;
         cross_vld_q    <= 1'b0;
         cross_hw_q     <= '0;
         carry_q        <= 1'b0;
         carry_hw_q     <= '0;
      end else if (bus.pcd_flush) begin
         out_vld_q <= 1'b0;
         carry_q   <= 1'b0;
      end else if (take) begin
         out_vld_q      <= 1'b1;
         out_data_q     <= bus.pcd_in_data;
         bnd_q          <= bnd_d;
         br_q           <= br_d;
         ab_br_q        <= ab_br_d;
         first_br_vld_q <= first_br_vld_d;
         first_br_idx_q <= first_br_idx_d;
         cross_vld_q    <= cin;
         cross_hw_q     <= carry_hw_q;
         carry_q        <= cout;
         carry_hw_q     <= bus.pcd_in_data[15:0];
      end else if (bus.pcd_out_rdy) begin
         out_vld_q <= 1'b0;
      end
   end

   assign bus.pcd_in_rdy           = in_rdy;
   assign bus.pcd_out_vld          = out_vld_q;
   assign bus.pcd_out_data         = out_data_q;
   assign bus.pcd_out_bnd          = bnd_q;
   assign bus.pcd_out_br           = br_q;
   assign bus.pcd_out_ab_br        = ab_br_q;
   assign bus.pcd_out_first_br_vld = first_br_vld_q;
   assign bus.pcd_out_first_br_idx = first_br_idx_q;
   assign bus.pcd_out_cross_vld    = cross_vld_q;
   assign bus.pcd_out_cross_hw     = cross_hw_q;

`ifdef CT_IFU_PCD_PERF_CNT_EN
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] cross_cnt_q, cross_cnt_d;

   always_comb begin
      line_cnt_d  = line_cnt_q;
      cross_cnt_d = cross_cnt_q;
      if (take && (line_cnt_q != '1)) begin
         line_cnt_d = line_cnt_q + 1'b1;
      end
      if (take && cin && (cross_cnt_q != '1)) begin
         cross_cnt_d = cross_cnt_q + 1'b1;
      end
   end

   // Not cleared by flush: these count history, not pipeline contents.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         line_cnt_q  <= '0;
         cross_cnt_q <= '0;
      end else begin
         line_cnt_q  <= line_cnt_d;
         cross_cnt_q <= cross_cnt_d;
      end
   end

   assign bus.pcd_perf_line_cnt  = line_cnt_q;
   assign bus.pcd_perf_cross_cnt = cross_cnt_q;
`endif

endmodule

// File: tb/tb_ct_ifu_pcd_bound_sel.sv
// Directed self-checking bench for ct_ifu_pcd_bound_sel.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same offset.
module tb_ct_ifu_pcd_bound_sel;
   import ct_ifu_pcd_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ct_ifu_pcd_bound_sel_if bus ();

   ct_ifu_pcd_bound_sel dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .bus            (bus)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Precode generator: bry1 walks from h1, bry0 walks from h2; br/ab_br masks are in bnd format.
   function automatic logic [31:0] mk_pc(input logic [127:0] d, input logic [7:0] brm,
                                         input logic [7:0] abm);
      logic [31:0] r;
      int p;
      r = '0;
      p = 0;
      while (p < 8) begin
         r[4*(7-p) + BRY1_POS] = 1'b1;
         p = p + ((d[16*(7-p) +: 2] == 2'b11) ? 2 : 1);
      end
      p = 1;
      while (p < 8) begin
         r[4*(7-p) + BRY0_POS] = 1'b1;
         p = p + ((d[16*(7-p) +: 2] == 2'b11) ? 2 : 1);
      end
      for (int b = 0; b < 8; b++) begin
         r[4*b + BR_POS]    = brm[b];
         r[4*b + AB_BR_POS] = abm[b];
      end
      return r;
   endfunction

   task automatic send(input logic redir, input logic [2:0] st, input logic [127:0] d,
                       input logic [7:0] brm, input logic [7:0] abm);
      bus.pcd_in_vld      = 1'b1;
      bus.pcd_in_redirect = redir;
      bus.pcd_in_start_hw = st;
      bus.pcd_in_data     = d;
      bus.pcd_in_pre_code = mk_pc(d, brm, abm);
      @(posedge clk);
      #1;
      bus.pcd_in_vld = 1'b0;
   endtask

   logic [127:0] d_nop, d_nop32, d_cr1, d_cr2, d_br;

   initial begin
      d_nop   = {8{16'h0001}};
      d_nop32 = {4{16'h0013, 16'h0000}};
      d_cr1   = {{7{16'h0001}}, 16'h0013};
      d_cr2   = {16'h0000, {7{16'h0001}}};
      d_br    = {16'h0001, 16'h0001, 16'hA001, 16'h0001, 16'hC001, 16'h0001, 16'h0001, 16'h0001};

      bus.pcd_flush       = 1'b0;
      bus.pcd_in_vld      = 1'b0;
      bus.pcd_in_redirect = 1'b0;
      bus.pcd_in_start_hw = 3'd0;
      bus.pcd_in_data     = '0;
      bus.pcd_in_pre_code = '0;
      bus.pcd_out_rdy     = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_vld", bus.pcd_out_vld, 1'b0);
      chk("rst_in_rdy", bus.pcd_in_rdy, 1'b1);
      chk("rst_bnd", bus.pcd_out_bnd, 8'h00);
      chk("rst_br", bus.pcd_out_br, 8'h00);
      chk("rst_first_idx", bus.pcd_out_first_br_idx, 3'd0);
      chk("rst_data", bus.pcd_out_data, 128'h0);
      chk("rst_cross_vld", bus.pcd_out_cross_vld, 1'b0);
      chk("rst_cross_hw", bus.pcd_out_cross_hw, 16'h0);
      chk("rst_carry", dut.carry_q, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Eight c.nops
      send(1'b0, 3'd0, d_nop, 8'h00, 8'h00);
      chk("nop_vld", bus.pcd_out_vld, 1'b1);
      chk("nop_bnd", bus.pcd_out_bnd, 8'hFF);
      chk("nop_br", bus.pcd_out_br, 8'h00);
      chk("nop_fbr_vld", bus.pcd_out_first_br_vld, 1'b0);
      chk("nop_cross", bus.pcd_out_cross_vld, 1'b0);
      chk("nop_carry", dut.carry_q, 1'b0);
      chk("nop_data", bus.pcd_out_data, d_nop);

      // Four 32-bit nops
      send(1'b0, 3'd0, d_nop32, 8'h00, 8'h00);
      chk("nop32_bnd", bus.pcd_out_bnd, 8'hAA);
      chk("nop32_carry", dut.carry_q, 1'b0);

      // Straddling instruction across two lines
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      chk("cr1_bnd", bus.pcd_out_bnd, 8'hFF);
      chk("cr1_carry", dut.carry_q, 1'b1);
      chk("cr1_cross", bus.pcd_out_cross_vld, 1'b0);
      send(1'b0, 3'd0, d_cr2, 8'h00, 8'h00);
      chk("cr2_cross_vld", bus.pcd_out_cross_vld, 1'b1);
      chk("cr2_cross_hw", bus.pcd_out_cross_hw, 16'h0013);
      chk("cr2_bnd", bus.pcd_out_bnd, 8'h7F);
      chk("cr2_carry", dut.carry_q, 1'b0);

      // Branch masks with entry at h2
      send(1'b0, 3'd1, d_br, 8'h28, 8'h20);
      chk("br_bnd", bus.pcd_out_bnd, 8'h7F);
      chk("br_br", bus.pcd_out_br, 8'h28);
      chk("br_ab_br", bus.pcd_out_ab_br, 8'h20);
      chk("br_fbr_vld", bus.pcd_out_first_br_vld, 1'b1);
      chk("br_fbr_idx", bus.pcd_out_first_br_idx, 3'd2);

      // Entry at h4 masks the branch at h3; first branch becomes h5
      send(1'b0, 3'd3, d_br, 8'h28, 8'h20);
      chk("br3_bnd", bus.pcd_out_bnd, 8'h1F);
      chk("br3_br", bus.pcd_out_br, 8'h08);
      chk("br3_ab_br", bus.pcd_out_ab_br, 8'h00);
      chk("br3_fbr_idx", bus.pcd_out_first_br_idx, 3'd4);

      // Carry pending, then redirect with entry at h5
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      chk("rd_pre_carry", dut.carry_q, 1'b1);
      send(1'b1, 3'd4, d_nop, 8'h00, 8'h00);
      chk("rd_cross", bus.pcd_out_cross_vld, 1'b0);
      chk("rd_bnd", bus.pcd_out_bnd, 8'h0F);
      chk("rd_carry", dut.carry_q, 1'b0);

      // Carry pending, non-redirect: start_hw ignored, bry0 chain used
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      send(1'b0, 3'd5, d_cr2, 8'h00, 8'h00);
      chk("cin_st_cross", bus.pcd_out_cross_vld, 1'b1);
      chk("cin_st_bnd", bus.pcd_out_bnd, 8'h7F);

      // Stall then flush alongside a presented line
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      bus.pcd_out_rdy     = 1'b0;
      bus.pcd_in_vld      = 1'b1;
      bus.pcd_in_data     = d_nop32;
      bus.pcd_in_start_hw = 3'd0;
      bus.pcd_in_pre_code = mk_pc(d_nop32, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("stall_vld", bus.pcd_out_vld, 1'b1);
         chk("stall_in_rdy", bus.pcd_in_rdy, 1'b0);
         chk("stall_data", bus.pcd_out_data, d_cr1);
         chk("stall_bnd", bus.pcd_out_bnd, 8'hFF);
         chk("stall_carry", dut.carry_q, 1'b1);
      end
      bus.pcd_out_rdy = 1'b1;
      bus.pcd_flush   = 1'b1;
      @(posedge clk);
      #1;
      bus.pcd_flush  = 1'b0;
      bus.pcd_in_vld = 1'b0;
      chk("flush_vld", bus.pcd_out_vld, 1'b0);
      chk("flush_carry", dut.carry_q, 1'b0);
      @(posedge clk);
      #1;
      chk("flush_noacc_vld", bus.pcd_out_vld, 1'b0);
      chk("flush_noacc_data", bus.pcd_out_data, d_cr1);
      send(1'b0, 3'd0, d_cr2, 8'h00, 8'h00);
      chk("post_flush_cross", bus.pcd_out_cross_vld, 1'b0);
      chk("post_flush_bnd", bus.pcd_out_bnd, 8'hFF);

      // Reset mid-stream clears carry
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      rst = 1'b1;
      #2;
      chk("mrst_carry", dut.carry_q, 1'b0);
      chk("mrst_vld", bus.pcd_out_vld, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef CT_IFU_PCD_PERF_CNT_EN
      chk("perf_rst_line", bus.pcd_perf_line_cnt, 32'd0);
`endif
      send(1'b0, 3'd0, d_cr2, 8'h00, 8'h00);
      chk("mrst_cross", bus.pcd_out_cross_vld, 1'b0);
      chk("mrst_bnd", bus.pcd_out_bnd, 8'hFF);
`ifdef CT_IFU_PCD_PERF_CNT_EN
      send(1'b0, 3'd0, d_cr1, 8'h00, 8'h00);
      send(1'b0, 3'd0, d_cr2, 8'h00, 8'h00);
      chk("perf_line", bus.pcd_perf_line_cnt, 32'd3);
      chk("perf_cross", bus.pcd_perf_cross_cnt, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
